ic_fetch_seq: RTL



---
 rtl/ic_fetch_seq.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/ic_fetch_seq.sv
// Fetch sequencer between the CPU and the I-cache: issues requests, replays misses and
// reassembles 16/32-bit RISC-V instructions (including line straddles) from a halfword queue.
module ic_fetch_seq #(
    parameter int HQ_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [25:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [25:0] instr_pc,
    output logic [25:0] fetch_addr,
    output logic        fetch_en,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_data
);
    localparam int PTR_W = $clog2(HQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CR_W  = CNT_W + 2;

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t           state_q, state_d;
    logic [25:0]      fpc_q, fpc_d;
    logic [25:0]      dpc_q, dpc_d;
    logic             s1_v_q, s1_v_d, s2_v_q, s2_v_d;
    logic [25:0]      s1_addr_q, s1_addr_d, s2_addr_q, s2_addr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             instr_valid_q, instr_valid_d;
    logic [31:0]      instr_data_q, instr_data_d;
    logic [25:0]      instr_pc_q, instr_pc_d;
    logic [15:0]      hq_q [HQ_DEPTH];

    logic [PTR_W-1:0] rd_ptr_nx, wr_ptr_nx;
    logic [15:0]      hw0, hw1;
    logic [CR_W-1:0]  credit_sum;
    logic             credit_ok, hit, replay, issue, load_out;
    logic [1:0]       push_n, pop_n;

    always_comb begin
        rd_ptr_nx  = rd_ptr_q + PTR_W'(1);
        wr_ptr_nx  = wr_ptr_q + PTR_W'(1);
        hw0        = hq_q[rd_ptr_q];
        hw1        = hq_q[rd_ptr_nx];
        // Reserve queue space for every in-flight response plus the one being issued.
        credit_sum = CR_W'(count_q) + CR_W'({s1_v_q, 1'b0}) + CR_W'({s2_v_q, 1'b0}) + CR_W'(2);
        credit_ok  = credit_sum <= CR_W'(HQ_DEPTH);
        hit        = s2_v_q && fetch_valid;
        replay     = s2_v_q && !fetch_valid;
        issue      = (state_q == ST_RUN) && credit_ok && !replay && !redirect;
        load_out   = !instr_valid_q || instr_ready;

        fetch_en   = issue;
        fetch_addr = fpc_q;

        state_d    = state_q;
        fpc_d      = fpc_q;
        s1_v_d     = issue;
        s1_addr_d  = fpc_q;
        s2_v_d     = s1_v_q && !replay;
        s2_addr_d  = s1_addr_q;

        if (issue) begin
            fpc_d = fpc_q + ((fpc_q[2:0] == 3'b111) ? 26'd1 : 26'd2);
        end
        if (replay) begin
            fpc_d = s2_addr_q;
        end

        push_n = 2'd0;
        if (hit) begin
            push_n = (s2_addr_q[2:0] == 3'b111) ? 2'd1 : 2'd2;
        end

        pop_n         = 2'd0;
        instr_valid_d = instr_valid_q;
        instr_data_d  = instr_data_q;
        instr_pc_d    = instr_pc_q;
        if (load_out) begin
            if (hw0[1:0] != 2'b11 && count_q != '0) begin
                instr_valid_d = 1'b1;
                instr_data_d  = {16'h0000, hw0};
                instr_pc_d    = dpc_q;
                pop_n         = 2'd1;
            end else if (hw0[1:0] == 2'b11 && count_q >= CNT_W'(2)) begin
                instr_valid_d = 1'b1;
                instr_data_d  = {hw1, hw0};
                instr_pc_d    = dpc_q;
                pop_n         = 2'd2;
            end else begin
                instr_valid_d = 1'b0;
            end
        end

        count_d  = count_q + CNT_W'(push_n) - CNT_W'(pop_n);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_n);
        wr_ptr_d = wr_ptr_q + PTR_W'(push_n);
        dpc_d    = dpc_q + 26'(pop_n);

        // A redirect discards this cycle's response and extraction outright.
        if (redirect) begin
            state_d       = ST_RUN;
            fpc_d         = redirect_pc;
            dpc_d         = redirect_pc;
            s1_v_d        = 1'b0;
            s2_v_d        = 1'b0;
            push_n        = 2'd0;
            pop_n         = 2'd0;
            count_d       = '0;
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
            instr_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            fpc_q         <= '0;
            dpc_q         <= '0;
            s1_v_q        <= 1'b0;
            s2_v_q        <= 1'b0;
            s1_addr_q     <= '0;
            s2_addr_q     <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            instr_valid_q <= 1'b0;
            instr_data_q  <= '0;
            instr_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            fpc_q         <= fpc_d;
            dpc_q         <= dpc_d;
            s1_v_q        <= s1_v_d;
            s2_v_q        <= s2_v_d;
            s1_addr_q     <= s1_addr_d;
            s2_addr_q     <= s2_addr_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            instr_valid_q <= instr_valid_d;
            instr_data_q  <= instr_data_d;
            instr_pc_q    <= instr_pc_d;
        end
    end

    // Queue storage carries data only; occupancy is tracked by count/pointers.
    always_ff @(posedge clk) begin
        if (push_n != 2'd0) hq_q[wr_ptr_q] <= fetch_data[15:0];
        if (push_n == 2'd2) hq_q[wr_ptr_nx] <= fetch_data[31:16];
    end

    assign instr_valid = instr_valid_q;
    assign instr_data  = instr_data_q;
    assign instr_pc    = instr_pc_q;

endmodule
